// File: rtl/pc_alu_pkg.sv
// Shared encodings and default constants for the PC / ALU / branch unit.
package pc_alu_pkg;

    localparam int unsigned     PC_INC     = 4;
    localparam logic [31:0]     RESET_ADDR = 32'h0000_0000;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_AND    = 3'b010,
        ALU_OR     = 3'b011,
        ALU_XOR    = 3'b100,
        ALU_PASS_B = 3'b101
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_type_e;

endpackage

// File: rtl/pc_alu_branch_unit_ex_alu.sv
// Execute-stage ALU: shared adder for ADD/SUB, bitwise ops, Z/N/C/V flags.
module ex_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             c_out,
    output logic             over
);
    import pc_alu_pkg::*;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // Single adder: SUB is A + ~B + 1, so carry-out means A >= B unsigned.
    always_comb begin
        is_sub = (alu_op == ALU_SUB);
        b_eff  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    end

    // Operation select with overflow computed from operand/result signs.
    always_comb begin
        result = '0;
        c_out  = 1'b0;
        over   = 1'b0;
        case (alu_op_e'(alu_op))
            ALU_ADD: begin
                result = sum[WIDTH-1:0];
                c_out  = sum[WIDTH];
                over   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result = sum[WIDTH-1:0];
                c_out  = sum[WIDTH];
                over   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
        zero = (result == '0);
        neg  = result[WIDTH-1];
    end

endmodule

// File: rtl/pc_alu_branch_unit.sv
// Fetch PC register, execute ALU and branch condition decider.
module pc_alu_branch_unit #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = pc_alu_pkg::RESET_ADDR,
    parameter int unsigned      PC_INC     = pc_alu_pkg::PC_INC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_src,
    input  logic [WIDTH-1:0] jump_addr,
    output logic [WIDTH-1:0] i_addr,
    output logic             i_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             c_out,
    output logic             over,
    input  logic [2:0]       branch_type,
    output logic             branch_taken
);
    import pc_alu_pkg::*;

    // PC register: reset, then redirect beats stall beats increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            i_addr  <= RESET_ADDR;
            i_valid <= 1'b1;
        end else begin
            if (pc_src)
                i_addr <= jump_addr;
            else if (!stall)
                i_addr <= i_addr + WIDTH'(PC_INC);
            i_valid <= ~(stall & ~pc_src);
        end
    end

    ex_alu #(.WIDTH(WIDTH)) u_ex_alu (
        .a      (A),
        .b      (B),
        .alu_op (alu_op),
        .result (result),
        .zero   (zero),
        .neg    (neg),
        .c_out  (c_out),
        .over   (over)
    );

    // Branch decider: maps ALU flags to a taken decision.
    always_comb begin
        branch_taken = 1'b0;
        case (branch_type_e'(branch_type))
            BR_BEQ:  branch_taken = zero;
            BR_BNE:  branch_taken = ~zero;
            BR_BLT:  branch_taken = neg ^ over;
            BR_BGE:  branch_taken = ~(neg ^ over);
            BR_BLTU: branch_taken = ~c_out;
            BR_BGEU: branch_taken = c_out;
            default: branch_taken = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_pc_alu_branch_unit.sv
// Scoreboard bench: stimulus pushes model expectations, monitor compares at negedge.
module tb_pc_alu_branch_unit;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2,
                           OP_OR = 3'd3, OP_XOR = 3'd4, OP_PASSB = 3'd5;
    localparam logic [2:0] BT_NONE = 3'd0, BT_BEQ = 3'd1, BT_BNE = 3'd2,
                           BT_BLT = 3'd4, BT_BGE = 3'd5, BT_BLTU = 3'd6, BT_BGEU = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] jump_addr = '0;
    logic [31:0] i_addr;
    logic        i_valid;
    logic [31:0] A = '0, B = '0;
    logic [2:0]  alu_op = '0;
    logic [31:0] result;
    logic        zero, neg, c_out, over;
    logic [2:0]  branch_type = '0;
    logic        branch_taken;

    pc_alu_branch_unit #(.WIDTH(32), .RESET_ADDR(32'h0000_0000), .PC_INC(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
        .jump_addr(jump_addr), .i_addr(i_addr), .i_valid(i_valid),
        .A(A), .B(B), .alu_op(alu_op), .result(result), .zero(zero),
        .neg(neg), .c_out(c_out), .over(over),
        .branch_type(branch_type), .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          pc_known;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] res;
        logic        z, n, c, v, bt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // reference state
    bit          m_known = 0;
    logic [31:0] m_pc = '0;
    logic        m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural ALU/branch reference computed with wide integer arithmetic.
    function automatic exp_t model_alu(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op, input logic [2:0] bt);
        exp_t e;
        longint sa, sb, s;
        logic [63:0] u;
        logic lt_s, lt_u, eq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.c = 0; e.v = 0; e.res = '0;
        case (op)
            OP_ADD: begin
                u = {32'b0, a} + {32'b0, b};
                e.res = u[31:0]; e.c = u[32];
                s = sa + sb; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                e.res = a - b; e.c = (a >= b);
                s = sa - sb; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_AND:   e.res = a & b;
            OP_OR:    e.res = a | b;
            OP_XOR:   e.res = a ^ b;
            OP_PASSB: e.res = b;
            default:  e.res = '0;
        endcase
        e.z = (e.res == 0);
        e.n = e.res[31];
        // For SUB the flag conditions are exactly the operand comparisons.
        if (op == OP_SUB) begin
            eq = (a == b); lt_s = (sa < sb); lt_u = (a < b);
        end else begin
            eq = e.z; lt_s = e.n ^ e.v; lt_u = ~e.c;
        end
        case (bt)
            BT_BEQ:  e.bt = eq;
            BT_BNE:  e.bt = !eq;
            BT_BLT:  e.bt = lt_s;
            BT_BGE:  e.bt = !lt_s;
            BT_BLTU: e.bt = lt_u;
            BT_BGEU: e.bt = !lt_u;
            default: e.bt = 0;
        endcase
        return e;
    endfunction

    // One cycle: advance PC model for the edge just taken, apply new inputs, push expectation.
    task automatic step(input logic rst, input logic st, input logic ps, input logic [31:0] ja,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [2:0] bt);
        exp_t e;
        @(posedge clk);
        #1;
        if (!reset) begin
            m_pc = 32'h0; m_valid = 1'b1; m_known = 1;
        end else if (m_known) begin
            if (pc_src) m_pc = jump_addr;
            else if (!stall) m_pc = m_pc + 32'd4;
            m_valid = !(stall && !pc_src);
        end
        reset = rst; stall = st; pc_src = ps; jump_addr = ja;
        A = a; B = b; alu_op = op; branch_type = bt;
        e = model_alu(a, b, op, bt);
        e.pc_known = m_known; e.pc = m_pc; e.valid = m_valid;
        q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle; compare away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.pc_known) begin
                    chk("i_addr", i_addr, e.pc);
                    chk("i_valid", {31'b0, i_valid}, {31'b0, e.valid});
                end
                chk("result", result, e.res);
                chk("zero", {31'b0, zero}, {31'b0, e.z});
                chk("neg", {31'b0, neg}, {31'b0, e.n});
                chk("c_out", {31'b0, c_out}, {31'b0, e.c});
                chk("over", {31'b0, over}, {31'b0, e.v});
                chk("branch_taken", {31'b0, branch_taken}, {31'b0, e.bt});
            end
        end
    end

    initial begin
        logic [31:0] ra, rb, rj;
        // reset held for two edges, then release and count 4, 8
        step(0, 0, 0, 0, 32'd5, 32'd5, OP_SUB, BT_BEQ);
        step(0, 0, 0, 0, 32'd5, 32'd5, OP_SUB, BT_BNE);
        step(1, 0, 0, 0, 32'd5, 32'd5, OP_SUB, BT_BGEU);
        step(1, 0, 0, 0, 32'h8000_0000, 32'd1, OP_SUB, BT_BLT);
        // stall one cycle at i_addr=8
        step(1, 1, 0, 0, 32'h8000_0000, 32'd1, OP_SUB, BT_BGE);
        step(1, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, OP_ADD, BT_BEQ);
        step(1, 0, 0, 0, 32'd1, 32'd2, OP_SUB, BT_BLTU);
        // stall and redirect together
        step(1, 1, 1, 32'h100, 32'd1, 32'd2, OP_SUB, BT_BGEU);
        step(1, 0, 1, 32'hFFFF_FFFC, 32'd1, 32'd2, OP_SUB, BT_BLT);
        step(1, 0, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_AND, BT_NONE);
        step(1, 0, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_OR, BT_BEQ);
        step(1, 0, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_XOR, BT_BNE);
        step(1, 0, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_PASSB, BT_BLTU);
        step(1, 0, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd6, 3'd3);
        step(1, 0, 0, 0, 32'h7FFF_FFFF, 32'd1, OP_ADD, BT_BLT);
        step(1, 0, 0, 0, 32'h1234_5678, 32'h1234_5678, 3'd7, BT_BEQ);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            ra = $urandom; rb = $urandom; rj = $urandom;
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) rj = 32'hFFFF_FFFC;
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 6) == 0), rj, ra, rb,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_alu_branch_unit.md
Name: pc_alu_branch_unit

Overview:
Fetch-address generator plus execute-stage arithmetic/branch core of the 5-stage RISC-V pipeline.
- A registered program counter advances by 4 per cycle, holds on a load-use stall, and redirects on a taken branch or jump.
- A combinational 32-bit ALU produces a result and Z/N/C/V flags.
- A combinational branch decider turns those flags into branch_taken.
- The surrounding pipeline registers pc_src and jump_addr before they reach this block.

Parameters:
WIDTH, 32, datapath and address width
RESET_ADDR, 32'h0000_0000, i_addr value after reset
PC_INC, 4, increment applied per non-stalled cycle

Ports:
clk  input  1  clock, rising-edge
reset  input  1  synchronous, active-low reset (0 = reset)
stall  input  1  hazard stall; hold i_addr
pc_src  input  1  redirect request (registered jump OR branch_taken)
jump_addr  input  WIDTH  redirect target
i_addr  output  WIDTH  current fetch address (registered)
i_valid  output  1  fetched instruction is new; 0 = ID must reuse previous instruction
A  input  WIDTH  ALU operand A
B  input  WIDTH  ALU operand B
alu_op  input  3  ALU operation
result  output  WIDTH  ALU result
zero  output  1  result == 0
neg  output  1  result[WIDTH-1]
c_out  output  1  carry out of MSB
over  output  1  signed overflow
branch_type  input  3  branch condition select
branch_taken  output  1  condition true

Behaviour:
- Reset (reset==0 at posedge): i_addr <= RESET_ADDR, i_valid <= 1. ALU and decider are purely combinational and have no reset.
- PC update at each posedge when reset==1, in priority order:
  - pc_src=1: i_addr <= jump_addr. pc_src overrides stall.
  - else stall=1: i_addr holds.
  - else: i_addr <= i_addr + PC_INC, mod 2^WIDTH (wraps 0xFFFFFFFC -> 0).
- i_valid is registered: i_valid <= ~(stall & ~pc_src). It goes low for exactly the cycle after each stalled cycle and stays high after a redirect.
- jump_addr is used as given; no alignment check or masking.
- alu_op encoding (result; c_out; over):
  - 000 ADD: A+B; carry out of bit 31; over = (A[31]==B[31]) & (res[31]!=A[31]).
  - 001 SUB: A+~B+1; c_out = carry, so c_out=1 iff A>=B unsigned; over = (A[31]!=B[31]) & (res[31]!=A[31]).
  - 010 AND: A&B; c_out=0; over=0.
  - 011 OR: A|B; c_out=0; over=0.
  - 100 XOR: A^B; c_out=0; over=0.
  - 101 PASS_B: B; c_out=0; over=0.
  - 110, 111 reserved: result=0; c_out=0; over=0.
- zero and neg are always derived from the final result.
- Zero-latency combinational path from A/B/alu_op to every flag and to branch_taken.
- branch_type encoding (flags assume the ALU is performing SUB):
  - 000 NONE: 0
  - 001 BEQ: zero
  - 010 BNE: ~zero
  - 011 reserved: 0
  - 100 BLT: neg^over
  - 101 BGE: ~(neg^over)
  - 110 BLTU: ~c_out
  - 111 BGEU: c_out
- Mid-operation reset takes precedence over pc_src and stall.

Decomposition:
- Shared package pc_alu_pkg holds:
  - alu_op_e: ADD, SUB, AND, OR, XOR, PASS_B
  - branch_type_e: NONE, BEQ, BNE, BLT, BGE, BLTU, BGEU
  - PC_INC and RESET_ADDR constants
- One natural sub-module, ex_alu (adder/logic plus flag generation). The PC register and the branch decider stay inline in the top.

Test Plan:
- Reset held low for 2 cycles, then released: i_addr=0, i_valid=1; next cycles i_addr=4, 8, 12.
- At i_addr=8 assert stall for 1 cycle: i_addr stays 8; i_valid=0 the following cycle, then 12 and 1.
- stall=1 and pc_src=1 with jump_addr=0x100 together: next i_addr=0x100, i_valid=1. Also starting from i_addr=0xFFFFFFFC with no stall: next i_addr=0.
- SUB A=5 B=5: result=0, zero=1, c_out=1, over=0. BEQ -> 1, BNE -> 0, BGEU -> 1.
- SUB A=0x80000000 B=1: result=0x7FFFFFFF, neg=0, over=1. BLT -> 1, BGE -> 0. ADD A=0xFFFFFFFF B=1: result=0, c_out=1, zero=1.
- SUB A=1 B=2: result=0xFFFFFFFF, c_out=0. BLTU -> 1, BGEU -> 0, BLT -> 1. AND/OR/XOR/PASS_B of 0xF0F0_F0F0 and 0x0FF0_0FF0 give 0x00F0_00F0, 0xFFF0_FFF0, 0xFF00_FF00, 0x0FF0_0FF0 with c_out=over=0. NONE -> 0.
